// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and register-read classification helpers
// used by the IF/ID buffer and its hazard detector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  // Only two-source formats read rt; everything except j reads rs.
  function automatic logic op_reads_rt(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_BEQ, OP_SW: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_reads_rs(input logic [5:0] op);
    logic r;
    case (op)
      OP_J:    r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register that the load currently in EX is about to write.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] id_instr,
  input  logic             id_valid,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rt,
  output logic             hazard
);

  logic [5:0] opcode_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       rs_match_s;
  logic       rt_match_s;
  logic       unused_imm_s;

  assign unused_imm_s = ^id_instr[RT_LO-1:0];

  // Decode source fields and compare against the pending load destination.
  always_comb begin
    opcode_s   = id_instr[OP_HI:OP_LO];
    rs_s       = id_instr[RS_HI:RS_LO];
    rt_s       = id_instr[RT_HI:RT_LO];
    rs_match_s = op_reads_rs(opcode_s) & (rs_s == idex_rt);
    rt_match_s = op_reads_rt(opcode_s) & (rt_s == idex_rt);
    hazard     = id_valid & idex_memRead & (idex_rt != 5'd0) &
                 (rs_match_s | rt_match_s);
  end

endmodule

// File: rtl/if_id_hazard_buffer.sv
// IF/ID pipeline register with load-use stall, taken-branch squash and
// saturating stall/flush performance counters.
module if_id_hazard_buffer #(
  parameter int               WIDTH    = 32,
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(mips_pkg::NOP_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] if_instr,
  input  logic [WIDTH-1:0] if_add_pc,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_add_pc,
  output logic             id_valid,
  output logic             pc_write,
  output logic             ctrl_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] id_instr_r;
  logic [WIDTH-1:0] id_add_pc_r;
  logic             id_valid_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             hazard_s;
  logic             stall_s;

  hazard_detect #(.WIDTH(WIDTH)) u_hazard_detect (
    .id_instr     (id_instr_r),
    .id_valid     (id_valid_r),
    .idex_memRead (idex_memRead),
    .idex_rt      (idex_rt),
    .hazard       (hazard_s)
  );

  // A taken branch overrides any stall request in the same cycle.
  assign stall_s = hazard_s & ~branch_taken;

  // Pipeline register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr_r  <= NOP_WORD;
      id_add_pc_r <= {WIDTH{1'b0}};
      id_valid_r  <= 1'b0;
    end else if (branch_taken) begin
      id_instr_r  <= NOP_WORD;
      id_add_pc_r <= if_add_pc;
      id_valid_r  <= 1'b0;
    end else if (stall_s) begin
      id_instr_r  <= id_instr_r;
      id_add_pc_r <= id_add_pc_r;
      id_valid_r  <= id_valid_r;
    end else begin
      id_instr_r  <= if_instr;
      id_add_pc_r <= if_add_pc;
      id_valid_r  <= 1'b1;
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (branch_taken && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  // Fetch/decode control derived from registered state and EX feedback only.
  always_comb begin
    pc_write    = ~hazard_s | branch_taken;
    ctrl_bubble = hazard_s | ~id_valid_r | branch_taken;
  end

  assign id_instr  = id_instr_r;
  assign id_add_pc = id_add_pc_r;
  assign id_valid  = id_valid_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_if_id_hazard_buffer.sv
// Scoreboard bench for if_id_hazard_buffer: directed plan cases followed by
// random traffic, checked against a behavioural pipeline model.
module tb_if_id_hazard_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_instr = 32'h8C080004;
  logic [31:0] if_add_pc = 32'h0;
  logic        idex_memRead = 1'b0;
  logic [4:0]  idex_rt = 5'd0;
  logic        branch_taken = 1'b0;

  logic [31:0] id_instr, id_add_pc;
  logic        id_valid, pc_write, ctrl_bubble;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_id_instr, s_id_add_pc;
  logic        s_id_valid, s_pc_write, s_ctrl_bubble;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  if_id_hazard_buffer dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_add_pc(if_add_pc),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .id_instr(id_instr), .id_add_pc(id_add_pc), .id_valid(id_valid),
    .pc_write(pc_write), .ctrl_bubble(ctrl_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_hazard_buffer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_add_pc(if_add_pc),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .id_instr(s_id_instr), .id_add_pc(s_id_add_pc), .id_valid(s_id_valid),
    .pc_write(s_pc_write), .ctrl_bubble(s_ctrl_bubble),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          pc_chk;
    bit          valid;
    bit          pw;
    bit          cb;
    int          stall;
    int          flush;
    int          stall_s;
    int          flush_s;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model state: reset is asserted before the first edge, so it starts reset.
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  bit          m_pc_chk = 1'b1;
  bit          m_valid = 1'b0;
  int          m_stall = 0, m_flush = 0, m_stall_s = 0, m_flush_s = 0;

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  function automatic bit model_hazard(input logic [31:0] held, input bit valid,
                                      input bit mr, input logic [4:0] rt);
    logic [5:0] op = held[31:26];
    bit rd_rt = op inside {6'd0, 6'd4, 6'd43};
    bit rd_rs = (op != 6'd2);
    if (!valid || !mr || rt == 5'd0) return 1'b0;
    return (rd_rs && held[25:21] == rt) || (rd_rt && held[20:16] == rt);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs, record expected view, advance model.
  task automatic cycle(input bit rst, input logic [31:0] ins, input logic [31:0] pc,
                       input bit mr, input logic [4:0] rt, input bit br);
    exp_t e;
    bit hz;
    @(negedge clk);
    reset = rst; if_instr = ins; if_add_pc = pc;
    idex_memRead = mr; idex_rt = rt; branch_taken = br;
    hz = model_hazard(m_instr, m_valid, mr, rt);
    e.instr = m_instr; e.pc = m_pc; e.pc_chk = m_pc_chk; e.valid = m_valid;
    e.pw = !hz || br; e.cb = hz || !m_valid || br;
    e.stall = m_stall; e.flush = m_flush; e.stall_s = m_stall_s; e.flush_s = m_flush_s;
    q.push_back(e);
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_pc_chk = 1'b1; m_valid = 1'b0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else if (br) begin
      m_instr = 32'h0; m_pc_chk = 1'b0; m_valid = 1'b0;
      m_flush = sat_inc(m_flush, 65535); m_flush_s = sat_inc(m_flush_s, 3);
    end else if (hz) begin
      m_stall = sat_inc(m_stall, 65535); m_stall_s = sat_inc(m_stall_s, 3);
    end else begin
      m_instr = ins; m_pc = pc; m_pc_chk = 1'b1; m_valid = 1'b1;
    end
  endtask

  // Monitor: compare what the DUT presents this cycle against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("id_instr", id_instr, e.instr);
      if (e.pc_chk) chk("id_add_pc", id_add_pc, e.pc);
      chk("id_valid", 32'(id_valid), 32'(e.valid));
      chk("pc_write", 32'(pc_write), 32'(e.pw));
      chk("ctrl_bubble", 32'(ctrl_bubble), 32'(e.cb));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.flush));
      chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(e.stall_s));
      chk("sat_flush_cnt", 32'(s_flush_cnt), 32'(e.flush_s));
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'b000000;
      1: op = 6'b000100;
      2: op = 6'b101011;
      3: op = 6'b100011;
      4: op = 6'b001000;
      5: op = 6'b000010;
      default: op = 6'b001111;
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  localparam logic [31:0] ADD  = 32'h01095020;
  localparam logic [31:0] LW   = 32'h8C080004;
  localparam logic [31:0] ADDI = 32'h21490005;

  initial begin
    logic [31:0] pc;
    logic [4:0]  rt;
    // Reset for two cycles, then normal flow.
    cycle(1'b1, LW, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, LW, 32'h0, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, ADD, 32'h4, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, LW, 32'h8, 1'b0, 5'd0, 1'b0);
    // add in ID vs load of $t0 in EX: one stall, then idex_rt=0 gives none.
    cycle(1'b0, ADD, 32'hC, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, LW, 32'h10, 1'b1, 5'd8, 1'b0);
    cycle(1'b0, ADD, 32'h10, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, LW, 32'h14, 1'b1, 5'd0, 1'b0);
    // addi does not read rt.
    cycle(1'b0, ADDI, 32'h18, 1'b0, 5'd0, 1'b0);
    cycle(1'b0, ADD, 32'h1C, 1'b1, 5'd9, 1'b0);
    // Flush wins over a simultaneous hazard.
    cycle(1'b0, LW, 32'h20, 1'b1, 5'd8, 1'b1);
    cycle(1'b0, ADD, 32'h40, 1'b0, 5'd0, 1'b0);
    // Five forced stalls saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) cycle(1'b0, LW, 32'h44, 1'b1, 5'd8, 1'b0);
    cycle(1'b0, LW, 32'h48, 1'b0, 5'd0, 1'b0);
    @(negedge clk); #3;
    chk("sat_hold_3", 32'(s_stall_cnt), 32'd3);
    // Reset in the middle of a stall.
    cycle(1'b0, ADD, 32'h4C, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, LW, 32'h50, 1'b1, 5'd8, 1'b0);
    cycle(1'b0, LW, 32'h0, 1'b1, 5'd8, 1'b0);
    // Random traffic.
    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      rt = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? m_instr[25:21] : m_instr[20:16])
                                       : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 49) == 0), rand_instr(), pc, $urandom_range(0, 1) == 1,
            rt, ($urandom_range(0, 7) == 0));
      pc = pc + 32'd4;
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
